// File: rtl/bsg_xnor_popcount_accum.sv
// Popcount/accumulate half of a binarized dot product: reduces a stream of XNOR
// similarity words into one signed (matches - mismatches) score per vector.
module bsg_xnor_popcount_accum #(
    parameter int width_p     = 16,
    parameter int acc_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   last_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [acc_width_p-1:0] sum_o,
    output logic                   ovf_o,
    input  logic                   ready_i
);

    localparam int pc_w_lp = $clog2(width_p + 1);

    logic                   s1_v_q, s1_v_d;
    logic [pc_w_lp-1:0]     s1_pc_q, s1_pc_d;
    logic                   s1_last_q, s1_last_d;
    logic [acc_width_p-1:0] acc_q, acc_d;
    logic                   ovf_acc_q, ovf_acc_d;
    logic                   v_o_q, v_o_d;
    logic [acc_width_p-1:0] sum_o_q, sum_o_d;
    logic                   ovf_o_q, ovf_o_d;

    logic                   stall;
    logic                   accept;
    logic                   s2_fire;
    logic [pc_w_lp-1:0]     popcount;
    logic [acc_width_p-1:0] term;
    logic [acc_width_p-1:0] acc_next;
    logic                   add_ovf;
    logic                   ovf_next;

    // Only a finished vector blocked behind an unconsumed result can stall.
    assign stall   = s1_v_q & s1_last_q & v_o_q & ~ready_i;
    assign ready_o = ~stall;
    assign accept  = v_i & ready_o;
    assign s2_fire = s1_v_q & ~stall;

    always_comb begin
        popcount = '0;
        for (int i = 0; i < width_p; i++) begin
            popcount = popcount + pc_w_lp'(data_i[i]);
        end
    end

    // term = 2*pc - width_p computed modulo 2^acc_width_p, which is its signed value.
    assign term     = acc_width_p'({s1_pc_q, 1'b0}) - acc_width_p'(width_p);
    assign acc_next = acc_q + term;
    assign add_ovf  = (acc_q[acc_width_p-1] == term[acc_width_p-1]) &&
                      (acc_next[acc_width_p-1] != acc_q[acc_width_p-1]);
    assign ovf_next = ovf_acc_q | add_ovf;

    always_comb begin
        s1_v_d    = s1_v_q;
        s1_pc_d   = s1_pc_q;
        s1_last_d = s1_last_q;
        if (!stall) begin
            s1_v_d = accept;
            if (accept) begin
                s1_pc_d   = popcount;
                s1_last_d = last_i;
            end
        end
    end

    always_comb begin
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        v_o_d     = v_o_q;
        sum_o_d   = sum_o_q;
        ovf_o_d   = ovf_o_q;
        if (v_o_q && ready_i) begin
            v_o_d = 1'b0;
        end
        if (s2_fire) begin
            if (s1_last_q) begin
                sum_o_d   = acc_next;
                ovf_o_d   = ovf_next;
                v_o_d     = 1'b1;
                acc_d     = '0;
                ovf_acc_d = 1'b0;
            end else begin
                acc_d     = acc_next;
                ovf_acc_d = ovf_next;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v_q    <= 1'b0;
            s1_pc_q   <= '0;
            s1_last_q <= 1'b0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            v_o_q     <= 1'b0;
            sum_o_q   <= '0;
            ovf_o_q   <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_pc_q   <= s1_pc_d;
            s1_last_q <= s1_last_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            v_o_q     <= v_o_d;
            sum_o_q   <= sum_o_d;
            ovf_o_q   <= ovf_o_d;
        end
    end

    assign v_o   = v_o_q;
    assign sum_o = sum_o_q;
    assign ovf_o = ovf_o_q;

endmodule
